// File: rtl/stm32_bus_pkg.sv
// ---------------------------------------------------------------------------
// stm32_bus_pkg
//   Shared definitions for the STM32 8-bit parallel bus sequencer:
//   opcode values, fixed command lengths, the sequencer state type and the
//   opcode -> (validity, bus direction, entry state, length) lookup.
// ---------------------------------------------------------------------------
package stm32_bus_pkg;

  // Opcodes carried on DATA_BUS[3:0] while DATA_SYNC is high
  localparam logic [3:0] OP_BUS_TEST     = 4'd0;
  localparam logic [3:0] OP_GET_PARAMS   = 4'd1;
  localparam logic [3:0] OP_SEND_PARAMS  = 4'd2;
  localparam logic [3:0] OP_TX_IQ        = 4'd3;
  localparam logic [3:0] OP_RX_IQ        = 4'd4;
  localparam logic [3:0] OP_SYNC_ASSERT  = 4'd5;
  localparam logic [3:0] OP_SYNC_RELEASE = 4'd6;
  localparam logic [3:0] OP_FLASH        = 4'd7;
  localparam logic [3:0] OP_GET_INFO     = 4'd8;

  // Byte counts of the fixed-length commands and of one RX IQ frame
  localparam int GET_PARAMS_LEN  = 19;
  localparam int SEND_PARAMS_LEN = 8;
  localparam int TX_IQ_LEN       = 8;
  localparam int IQ_FRAME_LEN    = 8;
  localparam int GET_INFO_LEN    = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOST_WR,   // host writes a fixed number of bytes (ops 1, 3)
    ST_HOST_RD,   // host reads a fixed number of bytes (ops 2, 8)
    ST_IQ_RD,     // endless stream of RX IQ frames (op 4)
    ST_TEST_IN,   // bus test, host->FPGA half (op 0)
    ST_TEST_OUT,  // bus test, FPGA->host half
    ST_FL_CMD,    // flash bridge, host->FPGA half (op 7)
    ST_FL_ANS,    // flash bridge, FPGA->host half
    ST_HALT       // command finished, wait for the next DATA_SYNC
  } seq_state_t;

  typedef struct packed {
    logic       valid;       // opcode is defined
    logic       drives_bus;  // FPGA owns DATA_BUS from the sync cycle on
    seq_state_t entry;       // state entered after the sync cycle
  } op_info_t;

  function automatic op_info_t op_lookup(input logic [3:0] op);
    op_info_t info;
    info.valid      = 1'b1;
    info.drives_bus = 1'b0;
    info.entry      = ST_HALT;
    case (op)
      OP_BUS_TEST:     info.entry = ST_TEST_IN;
      OP_GET_PARAMS:   info.entry = ST_HOST_WR;
      OP_SEND_PARAMS:  begin info.entry = ST_HOST_RD; info.drives_bus = 1'b1; end
      OP_TX_IQ:        info.entry = ST_HOST_WR;
      OP_RX_IQ:        begin info.entry = ST_IQ_RD;   info.drives_bus = 1'b1; end
      OP_SYNC_ASSERT:  info.entry = ST_HALT;
      OP_SYNC_RELEASE: info.entry = ST_HALT;
      OP_FLASH:        info.entry = ST_FL_CMD;
      OP_GET_INFO:     begin info.entry = ST_HOST_RD; info.drives_bus = 1'b1; end
      default: begin
        info.valid = 1'b0;
        info.entry = ST_IDLE;
      end
    endcase
    return info;
  endfunction

  // Byte count of a fixed-length command; 0 for opcodes without one
  function automatic logic [7:0] op_len(input logic [3:0] op);
    logic [7:0] len;
    case (op)
      OP_GET_PARAMS:  len = 8'(GET_PARAMS_LEN);
      OP_SEND_PARAMS: len = 8'(SEND_PARAMS_LEN);
      OP_TX_IQ:       len = 8'(TX_IQ_LEN);
      OP_GET_INFO:    len = 8'(GET_INFO_LEN);
      default:        len = 8'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/stm32_bus_sequencer.sv
// ---------------------------------------------------------------------------
// stm32_bus_sequencer
//   Command/byte sequencer for the 8-bit STM32 parallel bus. The opcode is
//   taken from bus_in while DATA_SYNC is high; afterwards one byte is handled
//   per clk_in cycle and each byte is flagged to the consumers either as a
//   received byte (rx_stb/rx_byte) or as a request for a transmit byte
//   (tx_req, answered combinationally on tx_data).
//
//   All outputs are registered. A strobe cycle presents rx_stb/tx_req,
//   byte_idx and frame_done together; rx_byte is the bus value sampled on the
//   edge that produced rx_stb, and bus_out picks up tx_data on the edge that
//   ends a tx_req cycle.
//
// Ports
//   clk_in        bus clock, all logic on the rising edge
//   reset         synchronous, active-high
//   DATA_SYNC     bus_in carries an opcode this cycle
//   bus_in        DATA_BUS input value
//   rx2_en        RX IQ frames carry RX2 (double-length frames)
//   tx_data       consumer byte for (cmd_op, byte_idx) while tx_req is high
//   bus_out       registered DATA_BUS drive value
//   bus_oe        1 = FPGA drives DATA_BUS
//   cmd_op        opcode of the active command
//   cmd_start     pulse after a valid opcode
//   byte_idx      index of the current byte in the command / IQ frame
//   rx_stb        rx_byte holds the host byte at byte_idx
//   rx_byte       received host byte
//   tx_req        consumer must present tx_data for byte_idx
//   frame_done    pulse on the last byte of a fixed command or IQ frame
//   cmd_abort     pulse when a fixed-length command is cut short by DATA_SYNC
//   bad_op        pulse for an undefined opcode (> 8)
//   sync_reset_n  level, cleared by opcode 5, set by opcode 6
// ---------------------------------------------------------------------------
module stm32_bus_sequencer
  import stm32_bus_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             DATA_SYNC,
  input  logic [7:0]       bus_in,
  input  logic             rx2_en,
  input  logic [7:0]       tx_data,
  output logic [7:0]       bus_out,
  output logic             bus_oe,
  output logic [3:0]       cmd_op,
  output logic             cmd_start,
  output logic [IDX_W-1:0] byte_idx,
  output logic             rx_stb,
  output logic [7:0]       rx_byte,
  output logic             tx_req,
  output logic             frame_done,
  output logic             cmd_abort,
  output logic             bad_op,
  output logic             sync_reset_n
);

  localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  seq_state_t       state_reg,        state_next;
  logic [3:0]       cmd_op_reg,       cmd_op_next;
  logic [IDX_W-1:0] pos_reg,          pos_next;       // byte the FSM handles this cycle
  logic [IDX_W-1:0] byte_idx_reg,     byte_idx_next;
  logic [IDX_W-1:0] iq_len_reg,       iq_len_next;    // length of the IQ frame in flight
  logic [7:0]       bus_out_reg,      bus_out_next;
  logic             bus_oe_reg,       bus_oe_next;
  logic             rx_stb_reg,       rx_stb_next;
  logic [7:0]       rx_byte_reg,      rx_byte_next;
  logic             tx_req_reg,       tx_req_next;
  logic             frame_done_reg,   frame_done_next;
  logic             cmd_start_reg,    cmd_start_next;
  logic             cmd_abort_reg,    cmd_abort_next;
  logic             bad_op_reg,       bad_op_next;
  logic             sync_reset_n_reg, sync_reset_n_next;

  op_info_t         sync_info;
  logic [IDX_W-1:0] fixed_last;   // last index of the active fixed command
  logic [IDX_W-1:0] iq_len_cur;   // frame length, re-sampled at idx 0
  logic [IDX_W-1:0] pos_sat_inc;

  assign sync_info   = op_lookup(bus_in[3:0]);
  assign fixed_last  = IDX_W'(op_len(cmd_op_reg)) - IDX_ONE;
  assign iq_len_cur  = (pos_reg == '0)
                       ? (rx2_en ? IDX_W'(2 * IQ_FRAME_LEN) : IDX_W'(IQ_FRAME_LEN))
                       : iq_len_reg;
  // TEST and FLASH run open-ended; the index sticks at its maximum
  assign pos_sat_inc = (pos_reg == IDX_MAX) ? pos_reg : pos_reg + IDX_ONE;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      cmd_op_reg       <= 4'd0;
      pos_reg          <= '0;
      byte_idx_reg     <= '0;
      iq_len_reg       <= IDX_W'(IQ_FRAME_LEN);
      bus_out_reg      <= 8'd0;
      bus_oe_reg       <= 1'b0;
      rx_stb_reg       <= 1'b0;
      rx_byte_reg      <= 8'd0;
      tx_req_reg       <= 1'b0;
      frame_done_reg   <= 1'b0;
      cmd_start_reg    <= 1'b0;
      cmd_abort_reg    <= 1'b0;
      bad_op_reg       <= 1'b0;
      sync_reset_n_reg <= 1'b1;
    end else begin
      state_reg        <= state_next;
      cmd_op_reg       <= cmd_op_next;
      pos_reg          <= pos_next;
      byte_idx_reg     <= byte_idx_next;
      iq_len_reg       <= iq_len_next;
      bus_out_reg      <= bus_out_next;
      bus_oe_reg       <= bus_oe_next;
      rx_stb_reg       <= rx_stb_next;
      rx_byte_reg      <= rx_byte_next;
      tx_req_reg       <= tx_req_next;
      frame_done_reg   <= frame_done_next;
      cmd_start_reg    <= cmd_start_next;
      cmd_abort_reg    <= cmd_abort_next;
      bad_op_reg       <= bad_op_next;
      sync_reset_n_reg <= sync_reset_n_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cmd_op_next       = cmd_op_reg;
    pos_next          = pos_reg;
    byte_idx_next     = byte_idx_reg;
    iq_len_next       = iq_len_reg;
    // The consumer answered the previous tx_req during this cycle; the
    // byte is captured regardless of what happens to the command now.
    bus_out_next      = tx_req_reg ? tx_data : bus_out_reg;
    bus_oe_next       = 1'b0;
    rx_stb_next       = 1'b0;
    rx_byte_next      = rx_byte_reg;
    tx_req_next       = 1'b0;
    frame_done_next   = 1'b0;
    cmd_start_next    = 1'b0;
    cmd_abort_next    = 1'b0;
    bad_op_next       = 1'b0;
    sync_reset_n_next = sync_reset_n_reg;

    if (DATA_SYNC) begin
      cmd_op_next    = bus_in[3:0];
      pos_next       = '0;
      byte_idx_next  = '0;
      // Only fixed-length commands can be unfinished; they leave
      // HOST_WR/HOST_RD on their last byte.
      cmd_abort_next = (state_reg == ST_HOST_WR) || (state_reg == ST_HOST_RD);
      if (sync_info.valid) begin
        cmd_start_next = 1'b1;
        state_next     = sync_info.entry;
        bus_oe_next    = sync_info.drives_bus;
      end else begin
        bad_op_next    = 1'b1;
        state_next     = ST_IDLE;
      end
      if (bus_in[3:0] == OP_SYNC_ASSERT) begin
        sync_reset_n_next = 1'b0;
      end else if (bus_in[3:0] == OP_SYNC_RELEASE) begin
        sync_reset_n_next = 1'b1;
      end
    end else begin
      case (state_reg)
        ST_HOST_WR: begin
          rx_stb_next   = 1'b1;
          rx_byte_next  = bus_in;
          byte_idx_next = pos_reg;
          pos_next      = pos_reg + IDX_ONE;
          if (pos_reg == fixed_last) begin
            frame_done_next = 1'b1;
            state_next      = ST_HALT;
          end
        end
        ST_HOST_RD: begin
          tx_req_next   = 1'b1;
          bus_oe_next   = 1'b1;
          byte_idx_next = pos_reg;
          pos_next      = pos_reg + IDX_ONE;
          if (pos_reg == fixed_last) begin
            frame_done_next = 1'b1;
            state_next      = ST_HALT;
          end
        end
        ST_IQ_RD: begin
          tx_req_next   = 1'b1;
          bus_oe_next   = 1'b1;
          byte_idx_next = pos_reg;
          iq_len_next   = iq_len_cur;
          if (pos_reg == iq_len_cur - IDX_ONE) begin
            frame_done_next = 1'b1;
            pos_next        = '0;
          end else begin
            pos_next        = pos_reg + IDX_ONE;
          end
        end
        ST_TEST_IN, ST_FL_CMD: begin
          rx_stb_next   = 1'b1;
          rx_byte_next  = bus_in;
          byte_idx_next = pos_reg;
          state_next    = (state_reg == ST_TEST_IN) ? ST_TEST_OUT : ST_FL_ANS;
        end
        ST_TEST_OUT, ST_FL_ANS: begin
          // Both halves of a pair share one index; advance after the answer
          tx_req_next   = 1'b1;
          bus_oe_next   = 1'b1;
          byte_idx_next = pos_reg;
          pos_next      = pos_sat_inc;
          state_next    = (state_reg == ST_TEST_OUT) ? ST_TEST_IN : ST_FL_CMD;
        end
        default: begin
          // IDLE / HALT: bus released, no strobes, index held
        end
      endcase
    end
  end

  assign bus_out      = bus_out_reg;
  assign bus_oe       = bus_oe_reg;
  assign cmd_op       = cmd_op_reg;
  assign cmd_start    = cmd_start_reg;
  assign byte_idx     = byte_idx_reg;
  assign rx_stb       = rx_stb_reg;
  assign rx_byte      = rx_byte_reg;
  assign tx_req       = tx_req_reg;
  assign frame_done   = frame_done_reg;
  assign cmd_abort    = cmd_abort_reg;
  assign bad_op       = bad_op_reg;
  assign sync_reset_n = sync_reset_n_reg;

endmodule
